// File: rtl/dmem_lsu.sv
// Load/store unit between the core's execute stage and a variable-latency data memory.
// Aligns sub-word accesses, generates byte strobes, extends loads and stalls the core until completion.
module dmem_lsu #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              global_en,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_to_err;
    logic [TO_W-1:0]   r_cnt;
    logic              w_bad;
    logic              w_to_hit;

    // Illegal funct3, stores with unsigned-load encodings, or misaligned halfword/word.
    function automatic logic is_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0:    is_bad = 1'b0;
            3'd1:    is_bad = off[0];
            3'd2:    is_bad = (off != 2'b00);
            3'd4:    is_bad = we;
            3'd5:    is_bad = we | off[0];
            default: is_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (!we) begin
            lane_strb = 4'b0000;
        end else begin
            case (f3[1:0])
                2'd0:    lane_strb = 4'b0001 << off;
                2'd1:    lane_strb = 4'b0011 << off;
                default: lane_strb = 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    lane_data = {4{wd[7:0]}};
            2'd1:    lane_data = {2{wd[15:0]}};
            default: lane_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (f3)
            3'd0:    load_ext = {{24{sh[7]}}, sh[7:0]};
            3'd1:    load_ext = {{16{sh[15]}}, sh[15:0]};
            3'd4:    load_ext = {24'd0, sh[7:0]};
            3'd5:    load_ext = {16'd0, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    assign w_bad    = is_bad(lsu_we, lsu_funct3, lsu_addr[1:0]);
    assign w_to_hit = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (global_en && lsu_req && !w_bad) w_next = S_REQ;
            S_REQ:   if (mem_req_ready) w_next = S_WAIT;
            S_WAIT:  if (mem_resp_valid || w_to_hit) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_to_err <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_REQ) begin
                        r_we     <= lsu_we;
                        r_funct3 <= lsu_funct3;
                        r_addr   <= lsu_addr;
                        r_wdata  <= lsu_wdata;
                        r_rdata  <= 32'd0;
                        r_to_err <= 1'b0;
                    end
                end
                S_REQ: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A response arriving on the timeout cycle still counts as a normal completion.
                    if (mem_resp_valid) begin
                        r_rdata  <= r_we ? 32'd0 : load_ext(r_funct3, r_addr[1:0], mem_rdata);
                        r_to_err <= 1'b0;
                    end else if (w_to_hit) begin
                        r_rdata  <= 32'd0;
                        r_to_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while reset is held so the memory request drops at once.
    always_comb begin
        lsu_stall     = 1'b0;
        lsu_done      = 1'b0;
        lsu_rdata     = 32'd0;
        lsu_err       = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wstrb     = 4'b0000;
        mem_wdata     = 32'd0;
        if (rst) begin
            lsu_stall = lsu_req && !w_bad && (r_state != S_DONE);
            case (r_state)
                S_IDLE: lsu_err = lsu_req && w_bad;
                S_REQ: begin
                    mem_req_valid = 1'b1;
                    mem_we        = r_we;
                    mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
                    mem_wstrb     = lane_strb(r_we, r_funct3, r_addr[1:0]);
                    mem_wdata     = r_we ? lane_data(r_funct3, r_wdata) : 32'd0;
                end
                S_DONE: begin
                    lsu_done  = 1'b1;
                    lsu_rdata = r_rdata;
                    lsu_err   = r_to_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: alignment, strobes, extension, handshake, errors, timeout and reset.
module tb_dmem_lsu;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        global_en;
    logic        lsu_req;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    dmem_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .global_en(global_en),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full access from the IDLE accept cycle; returns one cycle after DONE, or in DONE when hold=1.
    task automatic access(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int rdy_dly, input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic [31:0] e_rdata, input bit hold);
        lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
        mem_rdata = rd; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        chk({nm, "_acc_stall"}, 32'(lsu_stall), 32'd1);
        chk({nm, "_acc_err"}, 32'(lsu_err), 32'd0);
        step();
        for (int i = 0; i <= rdy_dly; i++) begin
            mem_req_ready = (i == rdy_dly);
            chk({nm, "_req_valid"}, 32'(mem_req_valid), 32'd1);
            chk({nm, "_req_we"}, 32'(mem_we), 32'(we));
            chk({nm, "_req_addr"}, mem_addr, e_addr);
            chk({nm, "_req_strb"}, 32'(mem_wstrb), 32'(e_strb));
            if (we) chk({nm, "_req_wdata"}, mem_wdata, e_wdata);
            chk({nm, "_req_stall"}, 32'(lsu_stall), 32'd1);
            step();
        end
        mem_req_ready = 1'b0;
        chk({nm, "_wait_valid"}, 32'(mem_req_valid), 32'd0);
        chk({nm, "_wait_done"}, 32'(lsu_done), 32'd0);
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk({nm, "_done"}, 32'(lsu_done), 32'd1);
        chk({nm, "_done_err"}, 32'(lsu_err), 32'd0);
        chk({nm, "_done_stall"}, 32'(lsu_stall), 32'd0);
        if (!we) chk({nm, "_rdata"}, lsu_rdata, e_rdata);
        if (!hold) begin
            lsu_req = 1'b0;
            step();
            chk({nm, "_post_done"}, 32'(lsu_done), 32'd0);
        end
    endtask

    initial begin
        bit early;
        rst = 1'b0; global_en = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0;
        lsu_addr = 32'd0; lsu_wdata = 32'd0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_rdata = 32'd0;
        #12;
        chk("rst_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_done", 32'(lsu_done), 32'd0);
        chk("rst_err", 32'(lsu_err), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        access("lb103", 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0);
        access("lbu103", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 0, 32'h100, 4'h0, 32'h0, 32'h0000_0080, 1'b0);
        access("sh22", 1'b1, 3'd1, 32'h22, 32'hDEAD_BEEF, 32'h0, 3, 32'h20, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0);
        access("sb01", 1'b1, 3'd0, 32'h01, 32'h0000_005A, 32'h0, 1, 32'h0, 4'b0010, 32'h5A5A_5A5A, 32'h0, 1'b0);
        access("lh02", 1'b0, 3'd1, 32'h02, 32'h0, 32'hABCD_1234, 0, 32'h0, 4'h0, 32'h0, 32'hFFFF_ABCD, 1'b0);
        access("lh00", 1'b0, 3'd1, 32'h00, 32'h0, 32'hABCD_8234, 0, 32'h0, 4'h0, 32'h0, 32'hFFFF_8234, 1'b0);

        // Misaligned word, illegal funct3 and store with unsigned encoding.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'd2; lsu_addr = 32'h41;
        #1;
        chk("lw41_err", 32'(lsu_err), 32'd1);
        chk("lw41_stall", 32'(lsu_stall), 32'd0);
        step();
        chk("lw41_valid", 32'(mem_req_valid), 32'd0);
        chk("lw41_err_held", 32'(lsu_err), 32'd1);
        lsu_funct3 = 3'd3; lsu_addr = 32'h40;
        #1;
        chk("f3_3_err", 32'(lsu_err), 32'd1);
        chk("f3_3_stall", 32'(lsu_stall), 32'd0);
        step();
        chk("f3_3_valid", 32'(mem_req_valid), 32'd0);
        lsu_we = 1'b1; lsu_funct3 = 3'd4;
        #1;
        chk("sbu_err", 32'(lsu_err), 32'd1);
        step();
        chk("sbu_valid", 32'(mem_req_valid), 32'd0);

        // Enable low: a valid request is held off.
        lsu_we = 1'b0; lsu_funct3 = 3'd2; lsu_addr = 32'h40; global_en = 1'b0;
        step();
        chk("gen0_valid", 32'(mem_req_valid), 32'd0);
        chk("gen0_err", 32'(lsu_err), 32'd0);
        global_en = 1'b1;
        lsu_req = 1'b0;
        step();

        // Back-to-back with request held high through DONE.
        access("sw00", 1'b1, 3'd2, 32'h0, 32'h1122_3344, 32'h0, 0, 32'h0, 4'hF, 32'h1122_3344, 32'h0, 1'b1);
        lsu_we = 1'b0; lsu_funct3 = 3'd5; lsu_addr = 32'h2;
        step();
        chk("b2b_idle_valid", 32'(mem_req_valid), 32'd0);
        chk("b2b_idle_stall", 32'(lsu_stall), 32'd1);
        access("lhu02", 1'b0, 3'd5, 32'h2, 32'h0, 32'hABCD_1234, 0, 32'h0, 4'h0, 32'h0, 32'h0000_ABCD, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'd2; lsu_addr = 32'h300; mem_req_ready = 1'b1;
        step();
        chk("rstw_req_valid", 32'(mem_req_valid), 32'd1);
        step();
        mem_req_ready = 1'b0;
        chk("rstw_wait_stall", 32'(lsu_stall), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstw_valid", 32'(mem_req_valid), 32'd0);
        chk("rstw_stall", 32'(lsu_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        lsu_req = 1'b0;
        step();
        chk("rstw_idle_valid", 32'(mem_req_valid), 32'd0);
        access("lw300", 1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 32'h300, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Timeout: the response never arrives.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'd2; lsu_addr = 32'h200; mem_req_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        step();
        mem_req_ready = 1'b0;
        early = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            step();
            if (lsu_done) early = 1'b1;
        end
        chk("tmo_no_early_done", 32'(early), 32'd0);
        step();
        chk("tmo_done", 32'(lsu_done), 32'd1);
        chk("tmo_err", 32'(lsu_err), 32'd1);
        chk("tmo_rdata", lsu_rdata, 32'd0);
        lsu_req = 1'b0;
        step();
        chk("tmo_post_done", 32'(lsu_done), 32'd0);
        chk("tmo_post_err", 32'(lsu_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
